// File: rtl/em_pipe_reg_pkg.sv
// Shared CPU definitions for the E-to-M and M-to-W pipeline registers.
// Holds bubble encodings, write-data source selects and common widths.
package em_pipe_reg_pkg;

    localparam int          GPR_W         = 5;
    localparam int          TNEW_W_DEF    = 4;
    localparam logic [31:0] NOP_INSTR_DEF = 32'h0000_0000;
    localparam logic [31:0] RESET_PC_DEF  = 32'h0000_3000;

    typedef enum logic {
        WSEL_AO  = 1'b0,
        WSEL_PC8 = 1'b1
    } wsel_e;

endpackage

// File: rtl/em_pipe_reg_tnew_counter.sv
// Saturating Tnew down-counter: load-and-age, age-in-place, or clear to zero.
// Shared by the E-to-M and M-to-W pipeline registers.
module em_pipe_reg_tnew_counter #(
    parameter int TNEW_W = em_pipe_reg_pkg::TNEW_W_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clr,
    input  logic              load,
    input  logic              dec,
    input  logic [TNEW_W-1:0] d,
    output logic [TNEW_W-1:0] q
);

    function automatic logic [TNEW_W-1:0] sat_dec(input logic [TNEW_W-1:0] v);
        return (v == '0) ? '0 : v - TNEW_W'(1);
    endfunction

    logic [TNEW_W-1:0] tnew_p1;

    // Priority matches the pipeline register: clear beats load beats age
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tnew_p1 <= '0;
        end else if (clr) begin
            tnew_p1 <= '0;
        end else if (load) begin
            tnew_p1 <= sat_dec(d);
        end else if (dec) begin
            tnew_p1 <= sat_dec(tnew_p1);
        end
    end

    assign q = tnew_p1;

endmodule

// File: rtl/em_pipe_reg.sv
// Clocked E-to-M pipeline register with hold, bubble insertion, Tnew aging
// and the M-stage forwarding source presented to the hazard unit.
module em_pipe_reg
    import em_pipe_reg_pkg::*;
#(
    parameter int                DATA_W      = 32,
    parameter int                TNEW_W      = TNEW_W_DEF,
    parameter int                SIDE_W      = 8,
    parameter logic [DATA_W-1:0] NOP_INSTR   = NOP_INSTR_DEF,
    parameter logic [DATA_W-1:0] RESET_PC    = RESET_PC_DEF,
    parameter bit                DEC_ON_HOLD = 1'b1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              stall,
    input  logic              flush,
    input  logic              valid_in,
    input  logic [DATA_W-1:0] ir_in,
    input  logic [DATA_W-1:0] pc_in,
    input  logic [DATA_W-1:0] ao_in,
    input  logic [DATA_W-1:0] rt_in,
    input  logic              branch_op_in,
    input  logic              reg_write_in,
    input  logic [GPR_W-1:0]  writereg_in,
    input  logic              wsel_in,
    input  logic [TNEW_W-1:0] tnew_in,
    input  logic [SIDE_W-1:0] side_in,
    output logic              valid_o,
    output logic [DATA_W-1:0] ir_o,
    output logic [DATA_W-1:0] pc_o,
    output logic [DATA_W-1:0] ao_o,
    output logic [DATA_W-1:0] rt_o,
    output logic [DATA_W-1:0] pc8_o,
    output logic [GPR_W-1:0]  rt5_o,
    output logic              branch_op_o,
    output logic [GPR_W-1:0]  writereg_o,
    output logic [TNEW_W-1:0] tnew_o,
    output logic [SIDE_W-1:0] side_o,
    output logic              fwd_en,
    output logic [GPR_W-1:0]  fwd_reg,
    output logic [DATA_W-1:0] fwd_data
);

    logic              vld_p1;
    logic [DATA_W-1:0] ir_p1, pc_p1, ao_p1, rt_p1, pc8_p1;
    logic              branch_op_p1, reg_write_p1, wsel_p1;
    logic [GPR_W-1:0]  writereg_p1;
    logic [SIDE_W-1:0] side_p1;
    logic              load;
    logic              age_on_hold;

    assign load        = !flush && !stall;
    assign age_on_hold = !flush && stall && DEC_ON_HOLD;

    // E -> M boundary: flush loads the same bubble as reset
    always_ff @(posedge clk or negedge reset) begin
        if (!reset || flush) begin
            vld_p1       <= 1'b0;
            ir_p1        <= NOP_INSTR;
            pc_p1        <= RESET_PC;
            pc8_p1       <= RESET_PC + DATA_W'(8);
            ao_p1        <= '0;
            rt_p1        <= '0;
            branch_op_p1 <= 1'b0;
            reg_write_p1 <= 1'b0;
            wsel_p1      <= WSEL_AO;
            writereg_p1  <= '0;
            side_p1      <= '0;
        end else if (load) begin
            vld_p1       <= valid_in;
            ir_p1        <= ir_in;
            pc_p1        <= pc_in;
            pc8_p1       <= pc_in + DATA_W'(8);
            ao_p1        <= ao_in;
            rt_p1        <= rt_in;
            branch_op_p1 <= branch_op_in;
            reg_write_p1 <= reg_write_in;
            wsel_p1      <= wsel_in;
            writereg_p1  <= writereg_in;
            side_p1      <= side_in;
        end
    end

    em_pipe_reg_tnew_counter #(
        .TNEW_W (TNEW_W)
    ) u_tnew (
        .clk   (clk),
        .reset (reset),
        .clr   (flush),
        .load  (load),
        .dec   (age_on_hold),
        .d     (tnew_in),
        .q     (tnew_o)
    );

    assign valid_o     = vld_p1;
    assign ir_o        = ir_p1;
    assign pc_o        = pc_p1;
    assign pc8_o       = pc8_p1;
    assign ao_o        = ao_p1;
    assign rt_o        = rt_p1;
    assign rt5_o       = ir_p1[20:16];
    assign branch_op_o = branch_op_p1;
    assign writereg_o  = writereg_p1;
    assign side_o      = side_p1;

    // $0 and bubbles never forward; result must be ready (Tnew reached 0)
    assign fwd_reg  = writereg_p1;
    assign fwd_data = (wsel_p1 == WSEL_PC8) ? pc8_p1 : ao_p1;
    assign fwd_en   = vld_p1 && reg_write_p1 && (writereg_p1 != '0) && (tnew_o == '0);

endmodule

// File: tb/tb_em_pipe_reg.sv
// Directed-vector bench for em_pipe_reg with hand-computed expected values.
module tb_em_pipe_reg;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        stall = 1'b0, flush = 1'b0, valid_in = 1'b0;
    logic [31:0] ir_in = '0, pc_in = '0, ao_in = '0, rt_in = '0;
    logic        branch_op_in = 1'b0, reg_write_in = 1'b0, wsel_in = 1'b0;
    logic [4:0]  writereg_in = '0;
    logic [3:0]  tnew_in = '0;
    logic [7:0]  side_in = '0;

    logic        valid_o, branch_op_o, fwd_en;
    logic [31:0] ir_o, pc_o, ao_o, rt_o, pc8_o, fwd_data;
    logic [4:0]  rt5_o, writereg_o, fwd_reg;
    logic [3:0]  tnew_o;
    logic [7:0]  side_o;

    int errs = 0;
    int checks = 0;

    em_pipe_reg dut (
        .clk          (clk),
        .reset        (reset),
        .stall        (stall),
        .flush        (flush),
        .valid_in     (valid_in),
        .ir_in        (ir_in),
        .pc_in        (pc_in),
        .ao_in        (ao_in),
        .rt_in        (rt_in),
        .branch_op_in (branch_op_in),
        .reg_write_in (reg_write_in),
        .writereg_in  (writereg_in),
        .wsel_in      (wsel_in),
        .tnew_in      (tnew_in),
        .side_in      (side_in),
        .valid_o      (valid_o),
        .ir_o         (ir_o),
        .pc_o         (pc_o),
        .ao_o         (ao_o),
        .rt_o         (rt_o),
        .pc8_o        (pc8_o),
        .rt5_o        (rt5_o),
        .branch_op_o  (branch_op_o),
        .writereg_o   (writereg_o),
        .tnew_o       (tnew_o),
        .side_o       (side_o),
        .fwd_en       (fwd_en),
        .fwd_reg      (fwd_reg),
        .fwd_data     (fwd_data)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [31:0] ir, input logic [31:0] pc,
                         input logic [31:0] ao, input logic [31:0] rt, input logic br,
                         input logic rw, input logic [4:0] wr, input logic ws,
                         input logic [3:0] tn, input logic [7:0] sd);
        valid_in = v; ir_in = ir; pc_in = pc; ao_in = ao; rt_in = rt;
        branch_op_in = br; reg_write_in = rw; writereg_in = wr; wsel_in = ws;
        tnew_in = tn; side_in = sd;
    endtask

    initial begin
        // reset state with reset held across edges
        drive(1, 32'h8C88_0004, 32'h3010, 32'h55, 32'h66, 1, 1, 5'd8, 0, 4'd0, 8'hFF);
        tick(); tick();
        chk("rst_ir", ir_o, 32'h0);
        chk("rst_pc", pc_o, 32'h3000);
        chk("rst_pc8", pc8_o, 32'h3008);
        chk("rst_valid", valid_o, 0);
        chk("rst_side", side_o, 0);
        chk("rst_tnew", tnew_o, 0);
        chk("rst_fwd_en", fwd_en, 0);

        // load with pc 0x3010, then assert reset mid-cycle
        reset = 1'b1;
        tick();
        chk("pre_rst_pc", pc_o, 32'h3010);
        chk("pre_rst_valid", valid_o, 1);
        #2 reset = 1'b0;
        #1;
        chk("async_ir", ir_o, 32'h0);
        chk("async_pc", pc_o, 32'h3000);
        chk("async_pc8", pc8_o, 32'h3008);
        chk("async_valid", valid_o, 0);
        chk("async_fwd_en", fwd_en, 0);
        tick();
        reset = 1'b1;

        // lw $8,4($4): Tnew 2 -> 1 on load, no forward yet
        drive(1, 32'h8C88_0004, 32'h3040, 32'h1234, 32'hABCD, 0, 1, 5'd8, 0, 4'd2, 8'h5A);
        tick();
        chk("lw_tnew", tnew_o, 1);
        chk("lw_fwd_en", fwd_en, 0);
        chk("lw_rt5", rt5_o, 8);
        chk("lw_pc8", pc8_o, 32'h3048);
        chk("lw_rt", rt_o, 32'hABCD);

        // stall: other fields hold, Tnew ages to 0 and forwarding opens
        stall = 1'b1;
        drive(1, 32'hDEAD_BEEF, 32'h4000, 32'h9999, 32'h7777, 1, 1, 5'd3, 1, 4'd5, 8'h11);
        tick();
        chk("stall_tnew", tnew_o, 0);
        chk("stall_fwd_en", fwd_en, 1);
        chk("stall_ir", ir_o, 32'h8C88_0004);
        chk("stall_ao", ao_o, 32'h1234);
        chk("stall_side", side_o, 8'h5A);
        chk("stall_br", branch_op_o, 0);
        chk("stall_fwd_reg", fwd_reg, 8);
        chk("stall_fwd_data", fwd_data, 32'h1234);
        tick();
        chk("stall_tnew_sat", tnew_o, 0);
        chk("stall2_pc", pc_o, 32'h3040);
        stall = 1'b0;

        // jal: forward PC+8 into $31
        drive(1, 32'h0C00_0C00, 32'h3020, 32'h0, 32'h0, 1, 1, 5'd31, 1, 4'd0, 8'h00);
        tick();
        chk("jal_pc8", pc8_o, 32'h3028);
        chk("jal_fwd_data", fwd_data, 32'h3028);
        chk("jal_fwd_reg", fwd_reg, 31);
        chk("jal_fwd_en", fwd_en, 1);
        chk("jal_br", branch_op_o, 1);

        // destination $0 never forwards
        drive(1, 32'h0000_0020, 32'h3024, 32'h42, 32'h0, 0, 1, 5'd0, 0, 4'd0, 8'h00);
        tick();
        chk("zero_fwd_en", fwd_en, 0);
        chk("zero_ao", ao_o, 32'h42);

        // invalid instruction captures payload but cannot forward
        drive(0, 32'h0000_0020, 32'h3028, 32'h77, 32'h0, 0, 1, 5'd5, 0, 4'd0, 8'h3C);
        tick();
        chk("inv_valid", valid_o, 0);
        chk("inv_fwd_en", fwd_en, 0);
        chk("inv_ao", ao_o, 32'h77);
        chk("inv_side", side_o, 8'h3C);

        // flush wins over stall: bubble replaces the held instruction
        drive(1, 32'h2001_0005, 32'h3030, 32'h5, 32'h0, 0, 1, 5'd1, 0, 4'd3, 8'h01);
        tick();
        chk("pre_flush_ir", ir_o, 32'h2001_0005);
        chk("pre_flush_tnew", tnew_o, 2);
        stall = 1'b1;
        flush = 1'b1;
        tick();
        chk("flush_ir", ir_o, 32'h0);
        chk("flush_valid", valid_o, 0);
        chk("flush_pc", pc_o, 32'h3000);
        chk("flush_pc8", pc8_o, 32'h3008);
        chk("flush_tnew", tnew_o, 0);
        chk("flush_wr", writereg_o, 0);
        stall = 1'b0;
        flush = 1'b0;

        // PC+8 wraps modulo 2^32; Tnew 0 stays 0
        drive(1, 32'h0000_0020, 32'hFFFF_FFFC, 32'h1, 32'h0, 0, 1, 5'd9, 1, 4'd0, 8'h00);
        tick();
        chk("wrap_pc8", pc8_o, 32'h0000_0004);
        chk("wrap_tnew", tnew_o, 0);
        chk("wrap_fwd_data", fwd_data, 32'h0000_0004);
        chk("wrap_fwd_en", fwd_en, 1);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule

// File: doc/em_pipe_reg.md
Name: em_pipe_reg

Overview:
- Parametrised, clocked E-to-M pipeline register for the pipelined MIPS core. Replaces the combinational pass-through stage.
- Captures E-stage results and carries a valid bit and sideband payload.
- Supports hold (stall) and bubble insertion (flush).
- Ages the hazard Tnew counter each cycle and drives the M-stage forwarding source (register number, data, enable) to the hazard unit.

Parameters:
DATA_W, 32, width of IR/PC/AO/rt datapath words
TNEW_W, 4, width of Tnew counter
SIDE_W, 8, width of opaque sideband payload (control bits carried unchanged)
NOP_INSTR, 32'h0000_0000, IR value loaded on reset/flush (sll $0,$0,0)
RESET_PC, 32'h0000_3000, PC value loaded on reset/flush
DEC_ON_HOLD, 1, 1: Tnew keeps decrementing while held; 0: Tnew frozen while held

Ports:
clk  in  1  rising-edge clock
reset  in  1  asynchronous, active-low reset
stall  in  1  hold current contents
flush  in  1  load bubble next edge
valid_in  in  1  E-stage instruction is real
ir_in  in  DATA_W  E-stage instruction
pc_in  in  DATA_W  E-stage PC
ao_in  in  DATA_W  ALU output
rt_in  in  DATA_W  forwarded rt value (store data)
branch_op_in  in  1  branch-taken flag
reg_write_in  in  1  instruction writes GPR
writereg_in  in  5  destination GPR
wsel_in  in  1  write-data source: 0 AO, 1 PC+8
tnew_in  in  TNEW_W  Tnew as seen in E stage
side_in  in  SIDE_W  sideband control
valid_o  out  1  M-stage instruction is real
ir_o, pc_o, ao_o, rt_o  out  DATA_W  registered copies
pc8_o  out  DATA_W  pc_o + 8 (registered, computed on capture)
rt5_o  out  5  ir_o[20:16]
branch_op_o  out  1  registered branch flag
writereg_o  out  5  registered destination
tnew_o  out  TNEW_W  current Tnew of M-stage instruction
side_o  out  SIDE_W  registered sideband
fwd_en  out  1  M stage can forward this cycle
fwd_reg  out  5  forwarded GPR number
fwd_data  out  DATA_W  forwarded value

Behaviour:
- Reset (reset=0, async; takes effect immediately):
  - ir_o=NOP_INSTR, pc_o=RESET_PC, pc8_o=RESET_PC+8.
  - ao_o=rt_o=0, side_o=0, branch_op_o=0.
  - valid_o=0, reg_write(internal)=0, writereg_o=0, tnew_o=0.
  - Outputs hold reset values until the first rising edge after release.
- Update priority per rising edge: reset > flush > stall > load.
- Flush: same values as reset. A flush asserted during stall still wins: bubble loaded, held instruction lost.
- Stall: all fields hold except Tnew.
  - DEC_ON_HOLD=1: tnew_o <= (tnew_o==0) ? 0 : tnew_o-1.
  - DEC_ON_HOLD=0: tnew_o holds.
- Load: all *_o <= *_in; pc8_o <= pc_in+8 (mod 2^DATA_W wrap); tnew_o <= (tnew_in==0) ? 0 : tnew_in-1 (saturating, never underflows).
- rt5_o is combinational from ir_o[20:16].
- Latency: one cycle input to output.
- Forwarding (combinational from registered state):
  - fwd_reg = writereg_o.
  - fwd_data = wsel ? pc8_o : ao_o.
  - fwd_en = valid_o & reg_write & (writereg_o != 0) & (tnew_o == 0).
  - $0 is never forwarded. Bubbles never forward.
- valid_in=0 on load: captures payload but valid_o=0, so fwd_en=0.
- No internal state beyond the registers; no X propagation from invalid inputs to fwd_en.

Decomposition:
- Shared package (cpu_defs): NOP_INSTR, RESET_PC, WSEL_AO/WSEL_PC8 encodings, GPR index width (5), TNEW_W default.
- One natural sub-module, tnew_counter: saturating down-counter with load/hold/dec controls, reused by the M-to-W register.

Test Plan:
- Reset: drive reset=0 mid-cycle with pc_in=0x3010 loaded -> outputs immediately ir_o=0, pc_o=0x3000, pc8_o=0x3008, valid_o=0, fwd_en=0.
- Load lw-style instruction: tnew_in=2 -> tnew_o=1, fwd_en=0. Next edge with stall=1, DEC_ON_HOLD=1 -> tnew_o=0, fwd_en=1, other fields unchanged.
- jal-style load: pc_in=0x3020, wsel=1, writereg=31, tnew_in=0 -> pc8_o=0x3028, fwd_data=0x3028, fwd_reg=31, fwd_en=1.
- writereg_in=0, reg_write=1, tnew_in=0 -> fwd_en=0.
- flush=1 and stall=1 in same cycle -> bubble (ir_o=0, valid_o=0) loaded, not the held instruction.
- Wrap: pc_in=0xFFFF_FFFC -> pc8_o=0x0000_0004. tnew_in=0 on load -> tnew_o stays 0.
